grf_wb_arbiter: RTL and testbench

//  Shares the single GRF write port between the main pipeline write-back stage and the

---
 rtl/grf_arb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 70 +++++++
 rtl/grf_wb_arbiter.sv | 119 +++++++++++
 tb/tb_grf_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/grf_arb_pkg.sv
// Shared widths and the write-back request record used by the GRF write-port arbiter.
package grf_arb_pkg;

   localparam int REG_AW = 5;
   localparam int DATA_W = 32;

   // One pending GRF write: destination, data and the PC of the producing instruction.
   typedef struct packed {
      logic [REG_AW-1:0] a3;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] pc;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO holding MDU results until the GRF write port is idle.
// The head entry is visible without a read strobe so the arbiter can pop and
// register it in the same cycle.
module wb_fifo
   import grf_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push_i,
   input  wb_req_t push_data_i,
   input  logic    pop_i,
   output logic    full_o,
   output logic    empty_o,
   output wb_req_t head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   wb_req_t          mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // A full FIFO refuses a push even when the head leaves in the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Next-state for the circular pointers and occupancy count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers; reset empties the FIFO and drops its contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; entries need no reset since occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the W stage and the MDU.
// Pipeline writes always win; MDU results wait in wb_fifo and drain on cycles
// where the pipeline does not write a real register. A per-register pending
// scoreboard stalls decode until an issued MDU destination has been written.
module grf_wb_arbiter
   import grf_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_we,
   input  logic [REG_AW-1:0] pipe_a3,
   input  logic [DATA_W-1:0] pipe_wd,
   input  logic [DATA_W-1:0] pipe_pc,
   input  logic              md_issue,
   input  logic [REG_AW-1:0] md_issue_a3,
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [REG_AW-1:0] md_a3,
   input  logic [DATA_W-1:0] md_wd,
   input  logic [DATA_W-1:0] md_pc,
   input  logic [REG_AW-1:0] id_a1,
   input  logic [REG_AW-1:0] id_a2,
   input  logic [REG_AW-1:0] id_a3,
   output logic              stall,
   output logic              grf_we,
   output logic [REG_AW-1:0] grf_a3,
   output logic [DATA_W-1:0] grf_wd,
   output logic [DATA_W-1:0] grf_wpc
);

   localparam int NREG = 1 << REG_AW;

   logic      pipe_sel, fifo_push, fifo_pop, fifo_full, fifo_empty;
   wb_req_t   md_req, head, sel_req;
   logic      grf_we_q, grf_we_d;
   wb_req_t   grf_q, grf_d;
   logic [NREG-1:0] pending_q, pending_d;

   // A pipeline write to $0 is treated as an idle slot so the FIFO may drain.
   assign pipe_sel  = pipe_we && (pipe_a3 != '0);
   assign fifo_pop  = !pipe_sel && !fifo_empty;
   assign md_ready  = !fifo_full && !reset;
   // Results aimed at $0 complete the handshake but are never stored.
   assign fifo_push = md_valid && md_ready && (md_a3 != '0);
   assign md_req    = '{a3: md_a3, wd: md_wd, pc: md_pc};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (fifo_push),
      .push_data_i (md_req),
      .pop_i       (fifo_pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (head)
   );

   // Write-port select: pipeline first, then FIFO head, otherwise all-zero idle.
   always_comb begin
      sel_req  = '0;
      grf_we_d = 1'b0;
      if (pipe_sel) begin
         sel_req  = '{a3: pipe_a3, wd: pipe_wd, pc: pipe_pc};
         grf_we_d = 1'b1;
      end else if (fifo_pop) begin
         sel_req  = head;
         grf_we_d = 1'b1;
      end
      grf_d = sel_req;
   end

   // Registered GRF write port, one cycle after selection.
   always_ff @(posedge clk) begin
      if (reset) begin
         grf_we_q <= 1'b0;
         grf_q    <= '0;
      end else begin
         grf_we_q <= grf_we_d;
         grf_q    <= grf_d;
      end
   end

   assign grf_we  = grf_we_q;
   assign grf_a3  = grf_q.a3;
   assign grf_wd  = grf_q.wd;
   assign grf_wpc = grf_q.pc;

   // Scoreboard next state per register: an issue sets, a FIFO pop clears, set wins.
   assign pending_d[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NREG; gi++) begin : g_pending
         logic set_hit, clr_hit;
         assign set_hit = md_issue && (md_issue_a3 == REG_AW'(gi));
         assign clr_hit = fifo_pop && (head.a3 == REG_AW'(gi));
         assign pending_d[gi] = set_hit || (pending_q[gi] && !clr_hit);
      end
   endgenerate

   // Scoreboard register; reset forgets every outstanding MDU destination.
   always_ff @(posedge clk) begin
      if (reset) pending_q <= '0;
      else       pending_q <= pending_d;
   end

   // Decode hazard against any outstanding MDU destination ($0 is never pending).
   assign stall = ((id_a1 != '0) && pending_q[id_a1]) ||
                  ((id_a2 != '0) && pending_q[id_a2]) ||
                  ((id_a3 != '0) && pending_q[id_a3]);

   // Only one MDU result may be outstanding per register; re-issue is legal only
   // when the earlier result is being written in this very cycle.
   always_ff @(posedge clk) begin
      if (!reset && md_issue && (md_issue_a3 != '0))
         assert (!pending_q[md_issue_a3] || (fifo_pop && (head.a3 == md_issue_a3)));
   end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter with DEPTH=2: reset, pipeline priority,
// FIFO drain on idle cycles, back-pressure, scoreboard set/clear and mid-run reset.
module tb_grf_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_we;
   logic [4:0]  pipe_a3;
   logic [31:0] pipe_wd, pipe_pc;
   logic        md_issue;
   logic [4:0]  md_issue_a3;
   logic        md_valid, md_ready;
   logic [4:0]  md_a3;
   logic [31:0] md_wd, md_pc;
   logic [4:0]  id_a1, id_a2, id_a3;
   logic        stall, grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd, grf_wpc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   grf_wb_arbiter #(.DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .pipe_we     (pipe_we),
      .pipe_a3     (pipe_a3),
      .pipe_wd     (pipe_wd),
      .pipe_pc     (pipe_pc),
      .md_issue    (md_issue),
      .md_issue_a3 (md_issue_a3),
      .md_valid    (md_valid),
      .md_ready    (md_ready),
      .md_a3       (md_a3),
      .md_wd       (md_wd),
      .md_pc       (md_pc),
      .id_a1       (id_a1),
      .id_a2       (id_a2),
      .id_a3       (id_a3),
      .stall       (stall),
      .grf_we      (grf_we),
      .grf_a3      (grf_a3),
      .grf_wd      (grf_wd),
      .grf_wpc     (grf_wpc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_grf(input string tag, input logic we, input logic [4:0] a3,
                            input logic [31:0] wd, input logic [31:0] pc);
      check({tag, ".we"}, 32'(grf_we), 32'(we));
      check({tag, ".a3"}, 32'(grf_a3), 32'(a3));
      check({tag, ".wd"}, grf_wd, wd);
      check({tag, ".wpc"}, grf_wpc, pc);
      $display("step %-10s we=%0d a3=%0d wd=%h wpc=%h stall=%0d md_ready=%0d",
               tag, grf_we, grf_a3, grf_wd, grf_wpc, stall, md_ready);
   endtask

   initial begin
      reset = 1'b1; pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
      md_issue = 0; md_issue_a3 = 0; md_valid = 0; md_a3 = 0; md_wd = 0; md_pc = 0;
      id_a1 = 0; id_a2 = 0; id_a3 = 0;

      // Reset cycle, then two idle cycles.
      tick();
      check_grf("rst", 0, 0, 0, 0);
      check("rst.md_ready", 32'(md_ready), 0);
      check("rst.stall", 32'(stall), 0);
      reset = 1'b0;
      tick();
      check_grf("idle1", 0, 0, 0, 0);
      check("idle1.md_ready", 32'(md_ready), 1);
      tick();
      check("idle2.stall", 32'(stall), 0);
      check("idle2.md_ready", 32'(md_ready), 1);

      // Plain pipeline write, then a $0 write that must not reach the GRF.
      pipe_we = 1; pipe_a3 = 8; pipe_wd = 32'h1234; pipe_pc = 32'h3000;
      tick();
      check_grf("pipe8", 1, 8, 32'h1234, 32'h3000);
      pipe_a3 = 0; pipe_wd = 32'h9999;
      tick();
      check_grf("pipe0", 0, 0, 0, 0);
      pipe_we = 0;

      // Issue $9, stall on it, buffer its result behind two busy pipeline cycles.
      md_issue = 1; md_issue_a3 = 9; id_a1 = 9;
      #1 check("iss9.pre_stall", 32'(stall), 0);
      tick();
      md_issue = 0;
      check("iss9.stall", 32'(stall), 1);
      pipe_we = 1; pipe_a3 = 1; pipe_wd = 32'h11; pipe_pc = 32'h100;
      md_valid = 1; md_a3 = 9; md_wd = 32'hABCD; md_pc = 32'h200;
      #1 check("md9.ready", 32'(md_ready), 1);
      tick();
      md_valid = 0;
      check_grf("busy1", 1, 1, 32'h11, 32'h100);
      pipe_a3 = 2; pipe_wd = 32'h22; pipe_pc = 32'h104;
      tick();
      check_grf("busy2", 1, 2, 32'h22, 32'h104);
      check("busy2.stall", 32'(stall), 1);
      pipe_we = 0;
      tick();
      check_grf("drain9", 1, 9, 32'hABCD, 32'h200);
      check("drain9.stall", 32'(stall), 0);
      tick();
      check_grf("idle3", 0, 0, 0, 0);

      // Result to $0 is handshaken but never written.
      md_valid = 1; md_a3 = 0; md_wd = 32'hDEAD; md_pc = 32'h204;
      tick();
      md_valid = 0;
      check("z0.we1", 32'(grf_we), 0);
      tick();
      check("z0.we2", 32'(grf_we), 0);

      // Three results against DEPTH=2 while the pipeline is busy.
      md_issue = 1; md_issue_a3 = 10; tick();
      md_issue_a3 = 11; tick();
      md_issue_a3 = 12; tick();
      md_issue = 0;
      id_a1 = 10; id_a2 = 11; id_a3 = 12;
      #1 check("f3.stall", 32'(stall), 1);
      pipe_we = 1; pipe_a3 = 3; pipe_wd = 32'h33; pipe_pc = 32'h300;
      md_valid = 1; md_a3 = 10; md_wd = 32'hA0; md_pc = 32'h1000;
      tick();
      md_a3 = 11; md_wd = 32'hA1; md_pc = 32'h1004;
      #1 check("f3.ready1", 32'(md_ready), 1);
      tick();
      md_a3 = 12; md_wd = 32'hA2; md_pc = 32'h1008;
      #1 check("f3.ready_full", 32'(md_ready), 0);
      tick();
      check_grf("f3.busy", 1, 3, 32'h33, 32'h300);
      check("f3.still_full", 32'(md_ready), 0);
      pipe_we = 0;
      tick();
      check_grf("f3.pop10", 1, 10, 32'hA0, 32'h1000);
      check("f3.ready_after_pop", 32'(md_ready), 1);
      check("f3.stall_mid", 32'(stall), 1);
      tick();
      md_valid = 0;
      check_grf("f3.pop11", 1, 11, 32'hA1, 32'h1004);
      tick();
      check_grf("f3.pop12", 1, 12, 32'hA2, 32'h1008);
      check("f3.stall_done", 32'(stall), 0);
      tick();
      check_grf("f3.idle", 0, 0, 0, 0);
      id_a1 = 0; id_a2 = 0; id_a3 = 0;

      // Re-issue of $5 in the cycle its earlier result is popped: pending stays set.
      md_issue = 1; md_issue_a3 = 5; tick();
      md_issue = 0;
      pipe_we = 1; pipe_a3 = 4; pipe_wd = 32'h44; pipe_pc = 32'h400;
      md_valid = 1; md_a3 = 5; md_wd = 32'h55; md_pc = 32'h500;
      tick();
      md_valid = 0; pipe_we = 0;
      md_issue = 1; md_issue_a3 = 5;
      tick();
      md_issue = 0;
      id_a2 = 5;
      check_grf("r5.pop", 1, 5, 32'h55, 32'h500);
      #1 check("r5.stall", 32'(stall), 1);
      md_valid = 1; md_a3 = 5; md_wd = 32'h56; md_pc = 32'h504;
      tick();
      md_valid = 0;
      tick();
      check_grf("r5.pop2", 1, 5, 32'h56, 32'h504);
      check("r5.stall_clr", 32'(stall), 0);
      id_a2 = 0;

      // Reset with a full FIFO and two pending registers.
      md_issue = 1; md_issue_a3 = 13; tick();
      md_issue_a3 = 14; tick();
      md_issue = 0;
      pipe_we = 1; pipe_a3 = 6; pipe_wd = 32'h66; pipe_pc = 32'h600;
      md_valid = 1; md_a3 = 13; md_wd = 32'hD0; md_pc = 32'h1300;
      tick();
      md_a3 = 14; md_wd = 32'hD1; md_pc = 32'h1400;
      tick();
      md_valid = 0;
      id_a1 = 13; id_a2 = 14;
      #1 check("rf.full", 32'(md_ready), 0);
      check("rf.stall", 32'(stall), 1);
      reset = 1; pipe_we = 0;
      tick();
      check_grf("rf.rst", 0, 0, 0, 0);
      check("rf.rst_stall", 32'(stall), 0);
      check("rf.rst_ready", 32'(md_ready), 0);
      reset = 0;
      tick();
      check_grf("rf.after1", 0, 0, 0, 0);
      check("rf.after_ready", 32'(md_ready), 1);
      tick();
      check_grf("rf.after2", 0, 0, 0, 0);
      check("rf.after_stall", 32'(stall), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
